gate_response_checker: RTL and testbench
========================================

// Module: gate_response_checker
//
// PURPOSE
// Hardware self-test engine for the small combinational gates in the lab designs.
// Applies every input combination to a gate under test (GUT), waits a settle time,
// samples the gate output, and compares it against an expected truth table.
// Reports a mismatch count, the first failing vector and a pass flag.
// Sits beside any N-input gate module, e.g. the 2-input OR gate, as its on-chip checker.
//
// PARAMETERS
// N_IN    2         number of GUT inputs; vectors run 0 .. 2**N_IN-1
// TRUTH   4'b1110   expected output, bit v = expected dut_out for vector v (default = OR)
// SETTLE  2         cycles a vector is held before sampling; must be >= 1
//
// PORTS
// clk               in   1        rising-edge clock
// rst_n             in   1        asynchronous active-low reset
// start             in   1        1-cycle pulse; begins a run from IDLE or DONE
// dut_in            out  N_IN     vector driven to the GUT (registered)
// dut_out           in   1        GUT output
// busy              out  1        run in progress (SETTLE or CHECK state)
// done              out  1        run complete; held until the next start or reset
// pass              out  1        done && err_count==0
// err_count         out  N_IN+1   mismatch count for the current/last run
// first_fail_valid  out  1        at least one mismatch recorded this run
// first_fail_vec    out  N_IN     vector of the first mismatch (valid when first_fail_valid)
//
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; dut_in, err_count, first_fail_vec = 0;
//   busy, done, pass, first_fail_valid = 0. Takes effect mid-run; the run is abandoned.
// - States: IDLE, SETTLE, CHECK, DONE. All outputs are registered or decoded from state.
// - IDLE/DONE + start=1: vec<=0, cnt<=0, err_count<=0, first_fail_valid<=0,
//   first_fail_vec<=0, done<=0, pass<=0, next state SETTLE. Without start, remain.
// - SETTLE: dut_in=vec held stable; cnt increments each cycle; at cnt==SETTLE-1 -> CHECK.
// - CHECK (one cycle): compare dut_out with TRUTH[vec].
//     mismatch: err_count<=err_count+1; if !first_fail_valid, latch first_fail_vec<=vec
//     and set first_fail_valid.
//     vec==2**N_IN-1 -> DONE (done=1, pass=(final err_count==0)); else vec<=vec+1,
//     cnt<=0 -> SETTLE.
// - Timing: each vector occupies SETTLE+1 cycles (SETTLE cycles in SETTLE plus 1 in CHECK).
//   done rises 2**N_IN*(SETTLE+1) cycles after the edge that accepts start
//   (12 cycles for the defaults).
// - dut_in changes only on SETTLE entry; it holds the last vector in DONE and is 0 in IDLE.
// - start while busy: ignored; the run continues unaffected.
// - err_count is N_IN+1 bits wide and cannot overflow (max 2**N_IN); no saturation logic.
// - busy and done are never 1 together; pass implies done.
//
// TESTING
// 1 Correct OR GUT, defaults, start pulse -> dut_in steps 00,01,10,11 with 3 cycles each;
//   done=1 at cycle 12; err_count=0; pass=1; first_fail_valid=0.
// 2 GUT stuck-at-0, TRUTH=4'b1110 -> done, err_count=3, pass=0, first_fail_vec=2'b01,
//   first_fail_valid=1.
// 3 AND GUT checked against TRUTH=4'b1110 -> err_count=2, first_fail_vec=2'b01, pass=0.
// 4 start pulsed again at cycle 5 while busy -> ignored; done still at cycle 12, same results.
// 5 rst_n=0 while vec=2 -> all outputs 0 and state IDLE immediately; a following start
//   completes a clean run (pass=1).
// 6 Restart from DONE after scenario 2 with a good GUT -> err_count, first_fail_valid and
//   done clear on the accepting edge; the new run ends with pass=1.
//   Repeat scenario 1 with SETTLE=1 -> done at cycle 8.

Source files
------------

// File: rtl/gate_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_response_checker
// Description : Exhaustive self-test of an N-input combinational gate against
//               an expected truth table; reports mismatch count and first fail.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_response_checker #(
    parameter int                    N_IN   = 2,
    parameter logic [2**N_IN-1:0]    TRUTH  = 4'b1110,
    parameter int                    SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   dut_in,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              first_fail_valid,
    output logic [N_IN-1:0]   first_fail_vec
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int EW = N_IN + 1;
    localparam logic [CW-1:0]   C_CNT_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] C_VEC_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    logic [N_IN-1:0]  r_vec;
    logic [CW-1:0]    r_cnt;
    logic [EW-1:0]    r_err;
    logic             r_done;
    logic             r_pass;
    logic             r_ffv;
    logic [N_IN-1:0]  r_ffvec;

    logic             w_mismatch;
    logic [EW-1:0]    w_err_next;

    assign w_mismatch = (dut_out != TRUTH[r_vec]);
    assign w_err_next = r_err + EW'(w_mismatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_ffv   <= 1'b0;
            r_ffvec <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_vec   <= '0;
                        r_cnt   <= '0;
                        r_err   <= '0;
                        r_ffv   <= 1'b0;
                        r_ffvec <= '0;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == C_CNT_LAST) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        r_err <= w_err_next;
                        if (!r_ffv) begin
                            r_ffv   <= 1'b1;
                            r_ffvec <= r_vec;
                        end
                    end
                    // Last vector: pass must reflect this cycle's compare as well.
                    if (r_vec == C_VEC_LAST) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end else begin
                        r_vec   <= r_vec + N_IN'(1);
                        r_cnt   <= '0;
                        r_state <= S_SETTLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dut_in           = r_vec;
    assign busy             = (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err;
    assign first_fail_valid = r_ffv;
    assign first_fail_vec   = r_ffvec;

endmodule
`default_nettype wire

// File: tb/tb_gate_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_response_checker
// Description : Directed bench for gate_response_checker (SETTLE=2 and SETTLE=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_response_checker;

    logic       clk;
    logic       rst_n;
    logic       start, start2;
    logic [1:0] dut_in, dut_in2;
    logic       dut_out, dut_out2;
    logic       busy, done, pass, ffv;
    logic       busy2, done2, pass2, ffv2;
    logic [2:0] err, err2;
    logic [1:0] ffvec, ffvec2;
    int         gut_mode;   // 0 = OR, 1 = stuck-at-0, 2 = AND
    int         total;
    int         bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        dut_out = 1'b0;
        case (gut_mode)
            0: dut_out = dut_in[0] | dut_in[1];
            2: dut_out = dut_in[0] & dut_in[1];
            default: dut_out = 1'b0;
        endcase
    end
    assign dut_out2 = dut_in2[0] | dut_in2[1];

    gate_response_checker #(.N_IN(2), .TRUTH(4'b1110), .SETTLE(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err),
        .first_fail_valid(ffv), .first_fail_vec(ffvec)
    );

    gate_response_checker #(.N_IN(2), .TRUTH(4'b1110), .SETTLE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .dut_in(dut_in2), .dut_out(dut_out2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Returns at the negedge following the accepting edge.
    task automatic pulse_start(input int which);
        @(negedge clk);
        if (which == 0) start = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen; bounded.
    task automatic wait_done(input int which, output int n);
        n = 0;
        while (((which == 0) ? !done : !done2) && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_results(input string tag, input int e_err, input int e_ffv,
                                 input int e_ffvec, input int e_pass);
        check({tag, "_done"},  int'(done), 1);
        check({tag, "_busy"},  int'(busy), 0);
        check({tag, "_err"},   int'(err), e_err);
        check({tag, "_ffv"},   int'(ffv), e_ffv);
        check({tag, "_ffvec"}, int'(ffvec), e_ffvec);
        check({tag, "_pass"},  int'(pass), e_pass);
    endtask

    initial begin
        int n;
        total = 0; bad = 0;
        gut_mode = 0;
        start = 1'b0; start2 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_err",  int'(err), 0);
        check("rst_din",  int'(dut_in), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Scenario 1: good OR gate, trace the vector sequence.
        pulse_start(0);
        check("s1_busy0", int'(busy), 1);
        check("s1_din0",  int'(dut_in), 0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("s1_din_%0d", k), int'(dut_in), (k < 12) ? k / 3 : 3);
            check($sformatf("s1_done_%0d", k), int'(done), (k == 12) ? 1 : 0);
            check($sformatf("s1_excl_%0d", k), int'(busy & done), 0);
        end
        check_results("s1", 0, 0, 0, 1);

        // Scenario 2: stuck-at-0 gate.
        gut_mode = 1;
        pulse_start(0);
        wait_done(0, n);
        check("s2_lat", n, 12);
        check_results("s2", 3, 1, 1, 0);

        // Scenario 6: restart from DONE with a good gate; stats clear on accept.
        gut_mode = 0;
        pulse_start(0);
        check("s6_err_clr",  int'(err), 0);
        check("s6_ffv_clr",  int'(ffv), 0);
        check("s6_done_clr", int'(done), 0);
        check("s6_pass_clr", int'(pass), 0);
        wait_done(0, n);
        check("s6_lat", n, 12);
        check_results("s6", 0, 0, 0, 1);

        // Scenario 3: AND gate against OR table.
        gut_mode = 2;
        pulse_start(0);
        wait_done(0, n);
        check("s3_lat", n, 12);
        check_results("s3", 2, 1, 1, 0);

        // Scenario 4: start re-pulsed mid-run is ignored.
        gut_mode = 1;
        pulse_start(0);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("s4_din5", int'(dut_in), 1);
        n = 5;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("s4_lat", n, 12);
        check_results("s4", 3, 1, 1, 0);

        // Scenario 5: asynchronous reset mid-run while vector 2 is applied.
        gut_mode = 0;
        pulse_start(0);
        repeat (7) @(negedge clk);
        check("s5_din_pre", int'(dut_in), 2);
        #2 rst_n = 1'b0;
        #1;
        check("s5_busy", int'(busy), 0);
        check("s5_din",  int'(dut_in), 0);
        check("s5_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start(0);
        wait_done(0, n);
        check("s5_lat", n, 12);
        check_results("s5", 0, 0, 0, 1);

        // SETTLE=1 instance: two cycles per vector.
        pulse_start(1);
        wait_done(1, n);
        check("s1b_lat",  n, 8);
        check("s1b_pass", int'(pass2), 1);
        check("s1b_err",  int'(err2), 0);
        check("s1b_ffv",  int'(ffv2), 0);
        check("s1b_din",  int'(dut_in2), 3);
        check("s1b_busy", int'(busy2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
